// File: rtl/popcnt_driver.sv
// Stream front-end for the bit-count controller/datapath: accepts words, launches one
// count per word, and returns {word, count} results through a small result FIFO.
module popcnt_driver #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1),
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             pc_go,
    output logic [WIDTH-1:0] pc_num,
    input  logic             pc_done,
    input  logic [CNT_W-1:0] pc_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        ARM    = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   word_r;
    logic               pc_go_r;

    logic [WIDTH-1:0]   word_mem_r  [DEPTH];
    logic [CNT_W-1:0]   count_mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [OCC_W-1:0]   occ_r;

    logic               full_s;
    logic               empty_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;

    assign full_s    = (occ_r == OCC_W'(DEPTH));
    assign empty_s   = (occ_r == {OCC_W{1'b0}});
    // Only one count is ever in flight, so accepting against !full guarantees room for its push.
    assign in_ready  = rst_n & (state_r == IDLE) & ~full_s;
    assign accept_s  = in_valid & in_ready;
    // ARM exists so a pc_done left high by the previous result is never mistaken for this one.
    assign push_s    = (state_r == WAIT) & pc_done;
    assign pop_s     = ~empty_s & out_ready;

    assign pc_go     = pc_go_r;
    assign pc_num    = word_r;
    assign busy      = (state_r != IDLE);
    assign out_valid = ~empty_s;
    assign out_word  = word_mem_r[rd_ptr_r];
    assign out_count = count_mem_r[rd_ptr_r];

    // Next-state decode for the launch/arm/wait sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = LAUNCH;
                else          state_s = IDLE;
            end
            LAUNCH:  state_s = ARM;
            ARM:     state_s = WAIT;
            WAIT: begin
                if (pc_done) state_s = IDLE;
                else         state_s = WAIT;
            end
            default: state_s = IDLE;
        endcase
    end

    // Control state, captured word and the one-cycle go pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            word_r  <= {WIDTH{1'b0}};
            pc_go_r <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_go_r <= accept_s;
            if (accept_s) word_r <= in_data;
        end
    end

    // Result FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {OCC_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Result FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_mem_r[i]  <= {WIDTH{1'b0}};
                count_mem_r[i] <= {CNT_W{1'b0}};
            end
        end else if (push_s) begin
            word_mem_r[wr_ptr_r]  <= word_r;
            count_mem_r[wr_ptr_r] <= pc_count;
        end
    end
endmodule

// File: tb/tb_popcnt_driver.sv
// Bench for popcnt_driver: behavioural counter stub, result scoreboard, directed and random steps.
module tb_popcnt_driver;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, pc_go, pc_done, out_valid, out_ready, busy;
    logic [7:0] in_data, pc_num, out_word;
    logic [3:0] pc_count, out_count;

    popcnt_driver #(.WIDTH(8), .CNT_W(4), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pc_go(pc_go), .pc_num(pc_num), .pc_done(pc_done), .pc_count(pc_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_count(out_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Counter stub: fixed latency after go; in stale mode done lingers one extra cycle.
    int         lat = 1;
    bit         stale = 1'b0;
    int         cm_ctr;
    bit         cm_drop;
    logic [7:0] cm_num;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_done <= 1'b0; pc_count <= 4'd0; cm_ctr <= 0; cm_drop <= 1'b0; cm_num <= 8'd0;
        end else if (pc_go) begin
            cm_num <= pc_num;
            if (stale) begin cm_drop <= 1'b1; cm_ctr <= lat + 1; end
            else begin pc_done <= 1'b0; cm_ctr <= lat; end
        end else begin
            if (cm_drop) begin pc_done <= 1'b0; cm_drop <= 1'b0; end
            if (cm_ctr != 0) begin
                cm_ctr <= cm_ctr - 1;
                if (cm_ctr == 1) begin pc_done <= 1'b1; pc_count <= 4'($countones(cm_num)); end
            end
        end
    end

    typedef struct packed { logic [7:0] w; logic [3:0] c; } res_t;
    res_t exp_q[$];
    int   compared = 0, mismatched = 0, accepts = 0, gos = 0;
    bit   prev_fi = 1'b0;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: score handshakes about to happen, then advance to #1 after the edge.
    task automatic tick();
        bit   fi, fo;
        res_t e;
        fi = (in_valid === 1'b1) && (in_ready === 1'b1);
        fo = (out_valid === 1'b1) && (out_ready === 1'b1);
        chk("go_follows_accept", {11'd0, pc_go}, {11'd0, prev_fi});
        if (pc_go === 1'b1) gos++;
        if (fo) begin
            if (exp_q.size() == 0) chk("pop_unexpected", {11'd0, out_valid}, 12'd0);
            else begin
                e = exp_q.pop_front();
                chk("result", {out_word, out_count}, {e.w, e.c});
            end
        end
        if (fi) begin
            e.w = in_data; e.c = 4'($countones(in_data));
            exp_q.push_back(e);
            accepts++;
        end
        prev_fi = fi;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] w);
        int n = 0;
        in_valid = 1'b1; in_data = w;
        while (in_ready !== 1'b1 && n < 200) begin tick(); n++; end
        chk("accept_timeout", {11'd0, in_ready}, 12'd1);
        if (in_ready === 1'b1) tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 600) begin tick(); n++; end
        chk("drain_timeout", 12'(exp_q.size()), 12'd0);
        chk("drained_idle", {10'd0, out_valid, busy}, 12'd0);
    endtask

    initial begin
        logic [7:0] wb;
        int n;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {7'd0, out_valid, busy, pc_go, in_ready, 1'b0}, 12'd0);
        chk("reset_pc_num", {4'd0, pc_num}, 12'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", {11'd0, in_ready}, 12'd1);

        // Zero word: exact go/visibility latency
        out_ready = 1'b1;
        send(8'h00);
        chk("go_t1", {10'd0, pc_go, out_valid}, 12'b10);
        tick();
        chk("go_t2", {10'd0, pc_go, busy}, 12'b01);
        tick();
        chk("valid_t3", {11'd0, out_valid}, 12'd0);
        tick();
        chk("valid_t4", {3'd0, out_valid, out_word, out_count}, {1'b1, 8'h00, 4'd0} );
        drain();

        // Back-to-back words
        send(8'hFF); send(8'hA5); send(8'h01);
        drain();

        // Fill the FIFO with out_ready low; fifth word must stall
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'h11 * (i + 1)));
        in_valid = 1'b1; in_data = 8'h7E;
        repeat (12) tick();
        chk("full_stall", {9'd0, in_ready, busy, out_valid}, 12'b001);
        out_ready = 1'b1;
        send(8'h7E);
        drain();

        // Simultaneous push/pop with one entry held
        out_ready = 1'b0;
        send(8'hC3);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin tick(); n++; end
        wb = 8'h3C;
        send(wb);
        tick(); tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pushpop_head", {3'd0, out_valid, out_word, out_count}, {1'b1, wb, 4'd4});
        repeat (3) tick();
        chk("head_stable", {out_word, out_count}, {wb, 4'd4});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("occupancy_one", {11'd0, out_valid}, 12'd0);

        // Stale done from previous result must not be captured
        stale = 1'b1;
        out_ready = 1'b1;
        send(8'hFF);
        drain();
        send(8'h03);
        drain();
        stale = 1'b0;

        // Reset mid-WAIT with two entries buffered
        out_ready = 1'b0;
        send(8'hF0); send(8'h0F);
        repeat (6) tick();
        lat = 30;
        send(8'hAA);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midreset_outputs", {8'd0, out_valid, busy, pc_go, in_ready}, 12'd0);
        repeat (3) tick();
        chk("held_reset_outputs", {8'd0, out_valid, busy, pc_go, in_ready}, 12'd0);
        #2 rst_n = 1'b1;
        #1;
        chk("ready_post_reset", {11'd0, in_ready}, 12'd1);
        @(posedge clk); #1;
        lat = 1;
        out_ready = 1'b1;
        send(8'h5A);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin lat = $urandom_range(1, 5); stale = 1'($urandom_range(0, 1)); end
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        drain();
        chk("go_per_accept", 12'(gos), 12'(accepts));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
